// File: rtl/vga_timing_pkg.sv
// Default SVGA 800x600@60 raster constants and helpers that derive the
// line/frame totals and sync-region boundaries from the porch parameters.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 32'd800;
    localparam int unsigned DEF_H_FP     = 32'd40;
    localparam int unsigned DEF_H_SYNC   = 32'd128;
    localparam int unsigned DEF_H_BP     = 32'd88;
    localparam int unsigned DEF_V_ACTIVE = 32'd600;
    localparam int unsigned DEF_V_FP     = 32'd1;
    localparam int unsigned DEF_V_SYNC   = 32'd4;
    localparam int unsigned DEF_V_BP     = 32'd23;
    localparam int unsigned DEF_CW       = 32'd11;
    localparam int unsigned DEF_FW       = 32'd16;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned sync_begin(input int unsigned active, input int unsigned fp);
        return active + fp;
    endfunction

    function automatic int unsigned sync_finish(input int unsigned active, input int unsigned fp,
                                                input int unsigned sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter that wraps at TOTAL-1 plus combinational
// region flags (active, sync) for the current count.
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          w_rst,
    input  logic          step,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          in_active,
    output logic          in_sync
);

    localparam logic [CW-1:0] LAST      = CW'(axis_total(ACTIVE, FP, SYNC, BP) - 32'd1);
    localparam logic [CW-1:0] ACT_END   = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_BEG  = CW'(sync_begin(ACTIVE, FP));
    localparam logic [CW-1:0] SYNC_END  = CW'(sync_finish(ACTIVE, FP, SYNC));
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;
    logic          at_last_s;

    // Region decode of the current count; wrap is qualified by step.
    always_comb begin
        at_last_s = (cnt_r == LAST);
        wrap      = step & at_last_s;
        in_active = (cnt_r < ACT_END);
        in_sync   = (cnt_r >= SYNC_BEG) && (cnt_r < SYNC_END);
    end

    // Position counter: reset dominates, wrap returns to zero, otherwise +1 per step.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (wrap) begin
            cnt_r <= {CW{1'b0}};
        end else if (step) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v axis counters, a registered decode
// stage (position, syncs at configured polarity, strobes) and a frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned CW       = DEF_CW,
    parameter int unsigned FW       = DEF_FW
) (
    input  logic          clk,
    input  logic          w_rst,
    input  logic          pix_ce,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_cnt
);

    localparam logic [FW-1:0] FRAME_ONE = {{(FW-1){1'b0}}, 1'b1};

    logic [CW-1:0] h_cnt_s;
    logic [CW-1:0] v_cnt_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          h_act_s;
    logic          v_act_s;
    logic          h_sync_s;
    logic          v_sync_s;

    logic [CW-1:0] pos_x_s;
    logic [CW-1:0] pos_y_s;
    logic          act_s;
    logic          hsync_s;
    logic          vsync_s;
    logic          line_start_s;
    logic          frame_start_s;

    logic [CW-1:0] pos_x_r;
    logic [CW-1:0] pos_y_r;
    logic          hsync_r;
    logic          vsync_r;
    logic          active_r;
    logic          line_start_r;
    logic          frame_start_r;
    logic [FW-1:0] frame_cnt_r;
    logic          frame_pend_r;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (CW)
    ) u_h (
        .clk       (clk),
        .w_rst     (w_rst),
        .step      (pix_ce),
        .cnt       (h_cnt_s),
        .wrap      (h_wrap_s),
        .in_active (h_act_s),
        .in_sync   (h_sync_s)
    );

    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (CW)
    ) u_v (
        .clk       (clk),
        .w_rst     (w_rst),
        .step      (h_wrap_s),
        .cnt       (v_cnt_s),
        .wrap      (v_wrap_s),
        .in_active (v_act_s),
        .in_sync   (v_sync_s)
    );

    // Decode of the current (h, v); positions read zero outside the visible area.
    always_comb begin
        act_s         = h_act_s & v_act_s;
        line_start_s  = (h_cnt_s == {CW{1'b0}});
        frame_start_s = line_start_s && (v_cnt_s == {CW{1'b0}});
        hsync_s       = h_sync_s ? HS_POL : ~HS_POL;
        vsync_s       = v_sync_s ? VS_POL : ~VS_POL;
        if (act_s) begin
            pos_x_s = h_cnt_s;
            pos_y_s = v_cnt_s;
        end else begin
            pos_x_s = {CW{1'b0}};
            pos_y_s = {CW{1'b0}};
        end
    end

    // Output register stage; frame_pend delays the frame wrap by one pixel so the
    // frame count moves on the same edge that presents frame_start.
    always_ff @(posedge clk) begin
        if (w_rst) begin
            pos_x_r       <= {CW{1'b0}};
            pos_y_r       <= {CW{1'b0}};
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            active_r      <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_cnt_r   <= {FW{1'b0}};
            frame_pend_r  <= 1'b0;
        end else if (pix_ce) begin
            pos_x_r       <= pos_x_s;
            pos_y_r       <= pos_y_s;
            hsync_r       <= hsync_s;
            vsync_r       <= vsync_s;
            active_r      <= act_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
            frame_pend_r  <= v_wrap_s;
            if (frame_pend_r) begin
                frame_cnt_r <= frame_cnt_r + FRAME_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end else begin
            pos_x_r       <= pos_x_r;
            pos_y_r       <= pos_y_r;
            hsync_r       <= hsync_r;
            vsync_r       <= vsync_r;
            active_r      <= active_r;
            line_start_r  <= line_start_r;
            frame_start_r <= frame_start_r;
            frame_cnt_r   <= frame_cnt_r;
            frame_pend_r  <= frame_pend_r;
        end
    end

    assign pos_x       = pos_x_r;
    assign pos_y       = pos_y_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign active      = active_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised raster timing generator; successor to the fixed 800x600 SVGA sync block.
- All horizontal/vertical timing, counter width and sync polarity are parameters.
- A pixel clock-enable supports pixel rates below `clk`; all outputs are registered.
- Adds line/frame strobes and a frame counter; sits between the clock/reset source and the pixel renderer and VGA pins.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch (pixels)
- `H_SYNC`, 128, hsync pulse width
- `H_BP`, 88, horizontal back porch
- `V_ACTIVE`, 600, visible lines per frame
- `V_FP`, 1, vertical front porch (lines)
- `V_SYNC`, 4, vsync pulse width
- `V_BP`, 23, vertical back porch
- `HS_POL`, 1, hsync asserted level (1 = positive)
- `VS_POL`, 1, vsync asserted level
- `CW`, 11, coordinate/counter width; must hold `H_TOTAL-1` and `V_TOTAL-1`
- `FW`, 16, frame counter width
- `clk` in 1: system clock
- `w_rst` in 1: synchronous, active-high reset
- `pix_ce` in 1: pixel clock enable; timing advances only on `clk` edges with `pix_ce`=1
- `pos_x` out CW: current pixel column; 0 outside the active region
- `pos_y` out CW: current pixel line; 0 outside the active region
- `hsync` out 1: horizontal sync at `HS_POL` polarity
- `vsync` out 1: vertical sync at `VS_POL` polarity
- `active` out 1: high when both counters are inside the active region
- `line_start` out 1: one-pixel strobe at h=0 of every line
- `frame_start` out 1: one-pixel strobe at h=0, v=0
- `frame_cnt` out FW: completed-frame count; wraps modulo 2^FW

## Operation
- Derived totals: `H_TOTAL` = sum of the four H parameters (1056 by default); `V_TOTAL` = sum of the four V parameters (628 by default).
- Horizontal region order: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. The vertical axis uses the same order.
- Internal counters `h`, `v`:
  - On each `pix_ce`, `h` increments.
  - `h` wraps to 0 at `H_TOTAL-1`; `v` increments only on that wrap.
  - `v` wraps to 0 at `V_TOTAL-1` together with the `h` wrap.
  - `frame_cnt` increments on that combined wrap.
- Output stage: on each `pix_ce`, registers the decode of the current (`h`, `v`) before the counters advance. The decode covers pos, syncs, active and strobes.
- `pix_ce`=0: counters and every output hold their values; strobes hold too, so each is exactly one enabled pixel long.
- Reset (any cycle, including mid-line or mid-frame):
  - `h`, `v`, `frame_cnt` = 0; `pos_x`, `pos_y` = 0; `active`, `line_start`, `frame_start` = 0.
  - `hsync` = `!HS_POL`, `vsync` = `!VS_POL`.
  - Reset overrides `pix_ce`.
- Sync outputs are computed over the full v/h range; active porches carry no sync.
- Unsigned compares only; no arithmetic beyond +1 at CW/FW width.

## Timing
- Latency: outputs lag the internal counters by one enabled cycle.
- First enabled edge after `w_rst` falls: outputs show (0,0) with `active`=1, `line_start`=1, `frame_start`=1.
- `hsync` asserts for exactly `H_SYNC` enabled cycles per line; `vsync` asserts for exactly `V_SYNC` whole lines (`V_SYNC`·`H_TOTAL` enabled cycles).
- Line period is `H_TOTAL` enabled cycles; frame period is `H_TOTAL`·`V_TOTAL` enabled cycles.
- `frame_cnt` updates on the same edge on which `frame_start` rises.

## Structure
- Package `vga_timing_pkg`:
  - Default SVGA constants, listed above.
  - Helper functions for `H_TOTAL`, `V_TOTAL` and region boundaries.
- Sub-module `vga_axis_cnt`, instanced twice (h, v):
  - Parameters: `ACTIVE`, `FP`, `SYNC`, `BP`, `CW`.
  - Ports: `clk`, `w_rst`, `step`.
  - Outputs: `cnt`, `wrap` (combinational, true at TOTAL-1 with step), `in_active`, `in_sync`.
  - The v instance's `step` = the h instance's `wrap`.
- Top level: output register stage, polarity application, frame counter.

## Test plan
All scenarios except the last use small parameters: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), `pix_ce`=1, POL=1.
- Reset release: `w_rst` high for 3 cycles, then low.
  - During reset: all outputs 0, except syncs at `!POL`.
  - First edge after release: `pos`=(0,0), `active`=1, `line_start`=1, `frame_start`=1.
- Horizontal scan of one line:
  - `pos_x` runs 0..7 with `active`=1.
  - Cycles 10–12 of the line: `hsync`=1.
  - `line_start` recurs every 14 cycles.
- Full frame:
  - `vsync` high during lines 5–6 (28 cycles).
  - `frame_start` every 112 cycles.
  - `frame_cnt` counts 1, 2, 3 over three frames.
- `pix_ce` toggled 1/0 every cycle:
  - All periods double: line = 28 clk.
  - Strobes last 2 clk (the held cycle); no output changes on ce=0 cycles.
- Mid-frame reset: assert `w_rst` at h=5, v=3 with POL=0.
  - Next edge: counters 0, `hsync`=`vsync`=1.
  - After release: restart at (0,0) with `frame_start`.
- Default SVGA parameters:
  - Line period 1056 cycles; `hsync` width 128, starting at h=840.
  - Frame period 663168 cycles.
